// File: rtl/word_array_pkg.sv
// Shared types and helpers for the word-array memory.
package word_array_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 16;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  // Even parity over up to 64 data bits (callers zero-extend narrower words)
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/word_row.sv
// One clocked storage row; written when both the global write strobe and its select are high.
module word_row #(
  parameter int unsigned RW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          sel,
  input  logic [RW-1:0] wdata,
  output logic [RW-1:0] rdata
);

  logic [RW-1:0] q;

  always_ff @(posedge clk) begin
    if (we && sel) q <= wdata;
  end

  assign rdata = q;

endmodule

// File: rtl/word_array_mem.sv
// Word-addressable memory with request/response handshakes and a post-reset clear sweep.
// Optional WORD_ARRAY_PARITY_EN adds a per-row even-parity bit and the par_inj input.
module word_array_mem
  import word_array_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
`ifdef WORD_ARRAY_PARITY_EN
  input  logic             par_inj,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             busy
);

`ifdef WORD_ARRAY_PARITY_EN
  localparam int unsigned RW = WIDTH + 1;
`else
  localparam int unsigned RW = WIDTH;
`endif

  state_t        state, state_nx;
  logic [AW-1:0] clr_addr, clr_nx;
  logic          clearing;
  logic          accept;
  logic          in_range;
  logic          row_we;
  logic [AW-1:0] row_addr;
  logic [RW-1:0] row_wdata;
  logic [RW-1:0] row_q [DEPTH];
  logic [RW-1:0] rd_word;
  logic          rd_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    clr_nx    = clr_addr;
    clearing  = 1'b0;
    req_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      CLEAR: begin
        clearing = 1'b1;
        busy     = 1'b1;
        clr_nx   = clr_addr + AW'(1);
        if (clr_addr == AW'(DEPTH - 1)) begin
          state_nx = RUN;
          clr_nx   = '0;
        end
      end
      RUN: req_ready = !rsp_valid || rsp_ready;
      default: state_nx = CLEAR;
    endcase
  end

  // Extra top bit keeps the compare correct when DEPTH == 2**AW
  assign in_range = {1'b0, req_addr} < (AW + 1)'(DEPTH);
  assign accept   = req_valid && req_ready;

  always_comb begin
    row_we   = clearing || (accept && req_we && in_range);
    row_addr = clearing ? clr_addr : req_addr;
`ifdef WORD_ARRAY_PARITY_EN
    if (clearing) row_wdata = '0;
    else row_wdata = {even_parity(64'(req_wdata)) ^ par_inj, req_wdata};
`else
    row_wdata = clearing ? '0 : req_wdata;
`endif
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_row
    word_row #(.RW(RW)) u_row (
      .clk   (clk),
      .we    (row_we),
      .sel   (row_addr == AW'(g)),
      .wdata (row_wdata),
      .rdata (row_q[g])
    );
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (req_addr == AW'(i)) rd_word = row_q[i];
    end
`ifdef WORD_ARRAY_PARITY_EN
    rd_err = !in_range || (^rd_word);
`else
    rd_err = !in_range;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept && !req_we) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= in_range ? rd_word[WIDTH-1:0] : '0;
      rsp_err   <= rd_err;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_word_array_mem.sv
// Scoreboard bench: DEPTH=16 and DEPTH=12 instances share stimulus; each has its own reference model.
module tb_word_array_mem;

`ifdef WORD_ARRAY_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int DEP [2] = '{16, 12};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1, par_inj = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic [1:0] rdy, rv, re, bsy;
  logic [7:0] rd0, rd1;

  always #5 clk = ~clk;

  word_array_mem #(.WIDTH(8), .DEPTH(16), .AW(4)) u16 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef WORD_ARRAY_PARITY_EN
    .par_inj(par_inj),
`endif
    .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(re[0]), .busy(bsy[0])
  );

  word_array_mem #(.WIDTH(8), .DEPTH(12), .AW(4)) u12 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef WORD_ARRAY_PARITY_EN
    .par_inj(par_inj),
`endif
    .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(re[1]), .busy(bsy[1])
  );

  // Reference model: word contents, corrupted-parity flags, outstanding read responses
  logic [7:0] mem [2][16];
  logic       bad [2][16];
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  int         clr_cnt = 0;
  bit         started = 0;
  int         vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // One clock cycle: drive, check handshake state, then apply the edge to the model
  task automatic cyc(input logic rst, input logic v, input logic we, input logic [3:0] a,
                     input logic [7:0] wd, input logic inj, input logic rr);
    logic [1:0] acc;
    logic       exp_rdy;
    #1;
    rst_n = rst; req_valid = v; req_we = we; req_addr = a;
    req_wdata = wd; par_inj = inj; rsp_ready = rr;
    #1;
    acc = '0;
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        exp_rdy = (clr_cnt >= DEP[k]) && (qsize(k) == 0 || rr);
        chk($sformatf("busy%0d", DEP[k]), 32'(bsy[k]), 32'(clr_cnt < DEP[k]));
        chk($sformatf("req_ready%0d", DEP[k]), 32'(rdy[k]), 32'(exp_rdy));
        acc[k] = rst && v && exp_rdy;
      end
    end
    @(posedge clk);
    if (!rst) begin
      started = 1;
      clr_cnt = 0;
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 16; i++) begin
          mem[k][i] = '0;
          bad[k][i] = 1'b0;
        end
    end else if (started) begin
      if (clr_cnt < 1000) clr_cnt++;
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) begin
          if (we) begin
            if (int'(a) < DEP[k]) begin
              mem[k][a] = wd;
              bad[k][a] = inj & PAR;
            end
          end else begin
            logic [8:0] e;
            e = (int'(a) < DEP[k]) ? {bad[k][a], mem[k][a]} : 9'h100;
            if (k == 0) q0.push_back(e);
            else q1.push_back(e);
          end
        end
      end
    end
  endtask

  // Monitor: every response presented must match the queue head, held until taken
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("rsp_valid16", 32'(rv[0]), 32'(q0.size() != 0));
        if (rv[0] && q0.size() != 0) begin
          chk("rsp16", {23'b0, re[0], rd0}, {23'b0, q0[0]});
          if (rsp_ready) void'(q0.pop_front());
        end
        chk("rsp_valid12", 32'(rv[1]), 32'(q1.size() != 0));
        if (rv[1] && q1.size() != 0) begin
          chk("rsp12", {23'b0, re[1], rd1}, {23'b0, q1[0]});
          if (rsp_ready) void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 4'(i), 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) cyc(1, 1, i[0], 4'(i), 8'($urandom), 0, 1);
    cyc(1, 1, 0, 5, 0, 0, 1);
    cyc(1, 1, 1, 3, 8'h55, 0, 1);
    cyc(1, 1, 0, 3, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 0, 7, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 1, 13, 8'hAA, 0, 1);
    cyc(1, 1, 0, 13, 0, 0, 1);
    cyc(1, 1, 0, 11, 0, 0, 1);
    cyc(1, 1, 1, 2, 8'hCC, 1, 1);
    cyc(1, 1, 0, 2, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 9) < 7),
          1'($urandom),
          4'($urandom),
          8'($urandom),
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
